// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM state
// type and the lane merge/extract helpers used for sub-word accesses.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  // Replace the addressed byte/half lane of word with the low bits of data.
  // Word size returns data unchanged.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B:    r[{off, 3'b000} +: 8]      = data[7:0];
      SZ_H:    r[{off[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

  // Pull the addressed lane out of word and sign/zero-extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment check plus load extract / store merge.
// Ports:
//   size, off   request size and byte offset within the word
//   uns         zero-extend loads when set
//   word        current memory word (dm_dout)
//   wdata       right-aligned store data
//   err         misaligned or illegal-size access
//   rdata       extended load result
//   merged      word with the store lane replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    err = (size == 2'b11) ||
          (size == SZ_H && off[0]) ||
          (size == SZ_W && off != 2'b00);
  end

  assign rdata  = lane_extract(word, size, off, uns);
  assign merged = lane_merge(word, wdata, size, off);

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of a word-only data memory with combinational
// read and synchronous write. Loads and word stores complete in one cycle;
// byte/half stores read the word, merge, and write it back the next cycle.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_*                        CPU request (valid/ready handshake)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle registered response pulse
//   dm_we/dm_addr/dm_din/dm_dout data memory word port
module dm_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              dm_we,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout
);

  state_t            state;
  logic [ADDR_W-3:0] rmw_addr;
  logic [31:0]       rmw_data;
  logic              accept, mis;
  logic [31:0]       ext_data, merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  lsu_align u_align (
    .size   (req_size),
    .off    (req_addr[1:0]),
    .uns    (req_unsigned),
    .word   (dm_dout),
    .wdata  (req_wdata),
    .err    (mis),
    .rdata  (ext_data),
    .merged (merged)
  );

  // IDLE: address tracks the request; write only for an accepted, aligned
  // word store. RMW_WR: replay the latched merge, unless reset cuts it off.
  always_comb begin
    dm_addr = req_addr[ADDR_W-1:2];
    dm_din  = req_wdata;
    dm_we   = 1'b0;
    if (state == RMW_WR) begin
      dm_addr = rmw_addr;
      dm_din  = rmw_data;
      dm_we   = !rst;
    end else if (accept && req_we && !mis && req_size == SZ_W) begin
      dm_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rmw_addr  <= '0;
      rmw_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mis) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_we) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= ext_data;
            end else if (req_size == SZ_W) begin
              rsp_valid <= 1'b1;
            end else begin
              rmw_addr <= req_addr[ADDR_W-1:2];
              rmw_data <= merged;
              state    <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_en = 1'b0, clr = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          we_cnt = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  dm_lsu #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  // Data memory: combinational read, write at the clock edge.
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    if (dm_we) begin
      mem[dm_addr] <= dm_din;
      we_cnt <= we_cnt + 1;
    end
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [9:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Reference: independent shift/mask model of one access; updates ref_mem.
  task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] a, input logic [31:0] wd,
                        output logic [32:0] e);
    logic [31:0] w, v, m;
    int sh;
    e = '0;
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
      e = {1'b1, 32'd0};
    end else begin
      w = ref_mem[a[9:2]];
      sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
      m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (!we) begin
        v = (sz == 2'd2) ? w : ((w >> sh) & m);
        if (!uns && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        e = {1'b0, v};
      end else begin
        w = (sz == 2'd2) ? wd : ((w & ~(m << sh)) | ((wd & m) << sh));
        ref_mem[a[9:2]] = w;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b1;
    drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; clr = 1'b0;
    @(negedge clk);
    checks += 5;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we got %b exp 0", dm_we); end
  endtask

  task automatic test_load;
    logic [1:0]  sz [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0]  ad [4]  = '{10'h013, 10'h013, 10'h012, 10'h010};
    logic [31:0] ex [4]  = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8877, 32'h0000_6655};
    preload(8'h04, 32'h8877_6655);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, sz[i], un[i], ad[i], 32'h0);
      #1;
      checks += 2;
      if (dm_addr !== 8'h04) begin errors++; $display("FAIL load%0d_dm_addr got %h exp 04", i, dm_addr); end
      if (dm_we !== 1'b0) begin errors++; $display("FAIL load%0d_dm_we got %b exp 0", i, dm_we); end
      @(negedge clk);
      drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
      checks += 3;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL load%0d_valid got %b exp 1", i, rsp_valid); end
      if (rsp_rdata !== ex[i]) begin errors++; $display("FAIL load%0d_rdata got %h exp %h", i, rsp_rdata, ex[i]); end
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL load%0d_err got %b exp 0", i, rsp_err); end
    end
  endtask

  task automatic test_rmw;
    logic [1:0]  sz [2] = '{2'd1, 2'd0};
    logic [9:0]  ad [2] = '{10'h012, 10'h011};
    logic [31:0] wd [2] = '{32'h0000_BEEF, 32'h0000_00AB};
    logic [31:0] ex [2] = '{32'hBEEF_6655, 32'hBEEF_AB55};
    preload(8'h04, 32'h8877_6655);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 1, sz[i], 0, ad[i], wd[i]);
      #1;
      checks += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw%0d_ready_accept got %b exp 1", i, req_ready); end
      if (dm_we !== 1'b0) begin errors++; $display("FAIL rmw%0d_read_we got %b exp 0", i, dm_we); end
      @(negedge clk);
      // A competing request during the write-back must be ignored.
      drive(1, 1, 2'd2, 0, 10'h3FC, 32'hDEAD_BEEF);
      #1;
      checks += 5;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw%0d_ready got %b exp 0", i, req_ready); end
      if (dm_we !== 1'b1) begin errors++; $display("FAIL rmw%0d_we got %b exp 1", i, dm_we); end
      if (dm_addr !== 8'h04) begin errors++; $display("FAIL rmw%0d_addr got %h exp 04", i, dm_addr); end
      if (dm_din !== ex[i]) begin errors++; $display("FAIL rmw%0d_din got %h exp %h", i, dm_din, ex[i]); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw%0d_early_rsp got %b exp 0", i, rsp_valid); end
      @(negedge clk);
      drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
      checks += 5;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmw%0d_rsp got %b exp 1", i, rsp_valid); end
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rmw%0d_rdata got %h exp 0", i, rsp_rdata); end
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL rmw%0d_err got %b exp 0", i, rsp_err); end
      if (mem[4] !== ex[i]) begin errors++; $display("FAIL rmw%0d_mem got %h exp %h", i, mem[4], ex[i]); end
      if (mem[8'hFF] === 32'hDEAD_BEEF) begin errors++; $display("FAIL rmw%0d_ignored_req got %h exp not DEADBEEF", i, mem[8'hFF]); end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw%0d_pulse got %b exp 0", i, rsp_valid); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1, 1, 2'd2, 0, 10'h3FC, 32'h1234_5678);
    #1;
    checks += 3;
    if (dm_we !== 1'b1) begin errors++; $display("FAIL wrap_we got %b exp 1", dm_we); end
    if (dm_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr got %h exp ff", dm_addr); end
    if (dm_din !== 32'h1234_5678) begin errors++; $display("FAIL wrap_din got %h exp 12345678", dm_din); end
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_st_rsp got %b exp 1", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wrap_st_rdata got %h exp 0", rsp_rdata); end
    drive(1, 0, 2'd2, 0, 10'h3FC, 32'h0);
    @(negedge clk);
    drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
    checks += 2;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_ld_rsp got %b exp 1", rsp_valid); end
    if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wrap_ld_rdata got %h exp 12345678", rsp_rdata); end
  endtask

  task automatic test_errors;
    logic        we [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [9:0]  ad [3] = '{10'h001, 10'h006, 10'h008};
    int w0;
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks += 3;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err%0d_valid got %b exp 1", i-1, rsp_valid); end
        if (rsp_err !== 1'b1) begin errors++; $display("FAIL err%0d_err got %b exp 1", i-1, rsp_err); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got %h exp 0", i-1, rsp_rdata); end
      end
      drive(1, we[i], sz[i], 0, ad[i], 32'hCAFE_F00D);
      #1;
      checks++;
      if (dm_we !== 1'b0) begin errors++; $display("FAIL err%0d_dm_we got %b exp 0", i, dm_we); end
    end
    @(negedge clk);
    drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
    checks += 4;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err2_valid got %b exp 1", rsp_valid); end
    if (rsp_err !== 1'b1) begin errors++; $display("FAIL err2_err got %b exp 1", rsp_err); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL err2_rdata got %h exp 0", rsp_rdata); end
    if (we_cnt !== w0) begin errors++; $display("FAIL err_writes got %0d exp %0d", we_cnt, w0); end
  endtask

  task automatic test_reset_rmw;
    int w0;
    preload(8'h08, 32'h1122_3344);
    w0 = we_cnt;
    @(negedge clk);
    drive(1, 1, 2'd0, 0, 10'h020, 32'h0000_005A);
    @(negedge clk);
    drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin errors++; $display("FAIL rstrmw_we got %b exp 0", dm_we); end
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrmw_rsp got %b exp 0", rsp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstrmw_ready got %b exp 1", req_ready); end
    if (mem[8] !== 32'h1122_3344) begin errors++; $display("FAIL rstrmw_mem got %h exp 11223344", mem[8]); end
    if (we_cnt !== w0) begin errors++; $display("FAIL rstrmw_writes got %0d exp %0d", we_cnt, w0); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrmw_late_rsp got %b exp 0", rsp_valid); end
  endtask

  task automatic test_random;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic        we, uns;
    logic [1:0]  sz;
    logic [9:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 300 + 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_dup_rsp cycle %0d got rsp exp none", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rand_rsp cycle %0d got err=%b data=%h exp err=%b data=%h",
                     cyc, rsp_err, rsp_rdata, e[32], e[31:0]);
          end
        end
      end
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 10'($urandom_range(0, 15));
      wd = $urandom;
      if (cyc >= 300) drive(0, 0, 2'd0, 0, 10'h0, 32'h0);
      else if (!req_ready) drive(1, we, sz, uns, a, wd);   // must be ignored
      else if ($urandom_range(0, 3) == 0) drive(0, we, sz, uns, a, wd);
      else begin
        drive(1, we, sz, uns, a, wd);
        ref_op(we, sz, uns, a, wd, e);
        exp_q.push_back(e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost_rsp got %0d pending exp 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_rmw();
    test_back_to_back();
    test_errors();
    test_reset_rmw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
